multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle state sequencer that steps the RV32I datapath through FETCH, DECODE, EXEC, MEM and WB phases so that one single-port memory serves both instruction fetch and load/store. It sits beside the main control decoder. The decoder produces per-instruction controls. This block gates the decoder's register and memory write enables to the correct phase, drives IR/PC write strobes and handles the memory ready handshake. It also detects illegal opcodes and memory timeouts and keeps cycle and retired-instruction counters.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive wait cycles allowed on one memory request before a fault.
- CNT_W, 32: width of the cycle and retire counters.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- opcode  in  7  Bits [6:0] of the instruction register.
- dec_RegWrite  in  1  RegWrite from the main control decoder.
- dec_MemRW  in  1  MemRW from the main control decoder (1 = store).
- mem_ready  in  1  Memory completes the pending access this cycle.
- mem_req  out  1  Memory access request.
- mem_we  out  1  Memory write enable.
- mem_addr_sel  out  1  Address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  Instruction register load strobe.
- pc_we  out  1  PC update strobe. The PC mux is steered by the decoder's PCSel.
- rf_we  out  1  Register file write enable.
- state  out  3  Current state encoding.
- fault  out  1  Sticky fault flag.
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- cycle_cnt  out  CNT_W  Cycles spent outside FAULT.
- instret_cnt  out  CNT_W  Retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7. Codes 5 and 6 are unreachable; if reached, the next state is FAULT with code 01.
- Legal opcodes:
  - LOAD 0000011
  - STORE 0100011
  - OP-IMM 0010011
  - OP 0110011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
- Any other opcode is illegal, including LUI and AUIPC.
- FETCH: drives mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1: ir_we=1 in the same cycle (Mealy), next state DECODE.
- DECODE: single cycle, no strobes.
  - Illegal opcode: next state FAULT, code 01.
  - Otherwise: next state EXEC.
- EXEC: single cycle, ALU evaluates.
  - BRANCH: pc_we=1, next state FETCH.
  - LOAD or STORE: next state MEM.
  - All others: next state WB.
- MEM: drives mem_req=1, mem_addr_sel=1, mem_we=dec_MemRW.
  - mem_ready=1 and STORE: pc_we=1, next state FETCH.
  - mem_ready=1 and LOAD: next state WB.
- WB: rf_we=dec_RegWrite, pc_we=1, next state FETCH.
- FAULT: all strobes 0, counters frozen. Held until rst.
- mem_ready is ignored outside FETCH and MEM.
- wait_cnt (internal):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH or MEM while mem_ready=0.
  - When wait_cnt==MEM_TIMEOUT and mem_ready=0, next state is FAULT with code 10. mem_req is therefore asserted for at most MEM_TIMEOUT+1 cycles.
  - mem_ready=1 in the timeout cycle wins over the fault.
- instret_cnt increments on every pc_we=1 cycle, so each instruction retires exactly once.
- cycle_cnt increments every cycle the state is not FAULT.
- Both counters wrap modulo 2^CNT_W.
- fault_code latches the first fault only.

## Timing
- Reset values (next edge after rst=1):
  - state=FETCH, wait_cnt=0.
  - cycle_cnt=0, instret_cnt=0.
  - fault=0, fault_code=00.
- While rst=1, all output strobes (mem_req, mem_we, ir_we, pc_we, rf_we) are forced to 0 combinationally.
- rst asserted mid-instruction aborts it. No pc_we or rf_we is issued in the reset cycle.
- state, fault and counters are registers.
- Strobes are combinational from state, plus mem_ready in FETCH and MEM.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - BRANCH: 3 cycles.
  - OP, OP-IMM, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- An illegal opcode reaches FAULT 2 cycles after the fetch completes.

## Test plan
- Reset, then OP opcode 0110011 with mem_ready tied 1. Required:
  - state sequence 0,1,2,4,0.
  - ir_we in cycle 0; rf_we and pc_we in cycle 3.
  - instret_cnt=1 and cycle_cnt=4 after 4 cycles.
- LOAD with 2 wait cycles in FETCH and 1 in MEM. Required:
  - 8-cycle instruction.
  - mem_addr_sel=1 only in MEM.
  - mem_we=0 throughout.
  - rf_we asserted only in WB.
- STORE with dec_MemRW=1, dec_RegWrite=0. Required:
  - mem_we=1 only in MEM.
  - pc_we on the mem_ready cycle.
  - rf_we never asserted.
  - 4 cycles total.
- Opcode 0110111 (LUI) fetched. Required:
  - FAULT entered after DECODE with fault=1, fault_code=01.
  - All strobes 0 and counters frozen for 20 cycles.
  - rst recovers to FETCH.
- MEM_TIMEOUT=3 with mem_ready held 0 in FETCH. Required:
  - mem_req high for exactly 4 cycles, then FAULT with code 10.
  - Repeat run with mem_ready=1 in the 4th request cycle: no fault.
- rst pulsed during MEM of a LOAD. Required: no rf_we or pc_we, state=FETCH and counters=0 on the next edge.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath sharing one
// single-port memory; gates decoder write enables by phase and flags illegal opcodes/timeouts.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             dec_RegWrite,
  input  logic             dec_MemRW,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP,
      OPC_BRANCH, OPC_JAL, OPC_JALR: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fault_q, fault_d;
  logic [1:0]         code_q, code_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               go_fault_s;
  logic [1:0]         fault_sel_s;
  logic               mem_req_s, mem_we_s, ir_we_s, pc_we_s, rf_we_s;

  // Next-state, raw strobes, fault capture and counter updates.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    fault_d      = fault_q;
    code_d       = code_q;
    go_fault_s   = 1'b0;
    fault_sel_s  = 2'b00;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    rf_we_s      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_we_s = 1'b1;
          wait_d  = WAIT_ZERO;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_MAX) begin
          go_fault_s  = 1'b1;
          fault_sel_s = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_DECODE: begin
        wait_d = WAIT_ZERO;
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          go_fault_s  = 1'b1;
          fault_sel_s = 2'b01;
        end
      end
      S_EXEC: begin
        wait_d = WAIT_ZERO;
        if (opcode == OPC_BRANCH) begin
          pc_we_s = 1'b1;
          state_d = S_FETCH;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_s    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we_s     = dec_MemRW;
        if (mem_ready) begin
          wait_d = WAIT_ZERO;
          if (opcode == OPC_STORE) begin
            pc_we_s = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_MAX) begin
          go_fault_s  = 1'b1;
          fault_sel_s = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_WB: begin
        wait_d  = WAIT_ZERO;
        rf_we_s = dec_RegWrite;
        pc_we_s = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        go_fault_s  = 1'b1;
        fault_sel_s = 2'b01;
      end
    endcase

    // Only the first fault is recorded; FAULT is terminal until reset anyway.
    if (go_fault_s) begin
      state_d = S_FAULT;
      if (!fault_q) begin
        fault_d = 1'b1;
        code_d  = fault_sel_s;
      end else begin
        code_d  = code_q;
      end
    end else begin
      fault_d = fault_q;
    end

    if (state_q != S_FAULT) begin
      cycle_d = cycle_q + CNT_ONE;
    end else begin
      cycle_d = cycle_q;
    end

    if (pc_we_s) begin
      instret_d = instret_q + CNT_ONE;
    end else begin
      instret_d = instret_q;
    end
  end

  // State, fault and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= WAIT_ZERO;
      fault_q   <= 1'b0;
      code_q    <= 2'b00;
      cycle_q   <= CNT_ZERO;
      instret_q <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Reset aborts the in-flight instruction, so every strobe is suppressed while it is high.
  assign mem_req     = mem_req_s & ~rst;
  assign mem_we      = mem_we_s  & ~rst;
  assign ir_we       = ir_we_s   & ~rst;
  assign pc_we       = pc_we_s   & ~rst;
  assign rf_we       = rf_we_s   & ~rst;
  assign state       = state_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected traces built from the phase rules,
// table-driven latency vectors, hand-written fault/reset sequences and random instructions.
module tb_multicycle_sequencer;

  localparam int TMO = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        dec_RegWrite = 1'b0;
  logic        dec_MemRW = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, fault;
  logic [2:0]  state;
  logic [1:0]  fault_code;
  logic [31:0] cycle_cnt, instret_cnt;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .dec_RegWrite(dec_RegWrite),
    .dec_MemRW(dec_MemRW), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .state(state), .fault(fault), .fault_code(fault_code),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       req, we, asel, irwe, pcwe, rfwe, rdy, flt;
    logic [1:0] code;
  } ent_t;

  typedef struct {
    logic [6:0] op;
    logic       rw, mrw;
    int         fw, mw, exp_len;
  } vec_t;

  ent_t        tr[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_cyc  = 32'd0;
  logic [31:0] m_ret  = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic push(input logic [2:0] st, input logic req, we, asel, irwe, pcwe, rfwe,
                      input logic rdy, flt, input logic [1:0] code);
    ent_t e;
    e.st = st; e.req = req; e.we = we; e.asel = asel; e.irwe = irwe;
    e.pcwe = pcwe; e.rfwe = rfwe; e.rdy = rdy; e.flt = flt; e.code = code;
    tr.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one legal instruction, from the phase rules.
  task automatic build_instr(input logic [6:0] op, input logic rw, mrw, input int fw, mw);
    logic is_ld, is_st, is_br;
    is_ld = (op == OP_LOAD); is_st = (op == OP_STORE); is_br = (op == OP_BRANCH);
    for (int i = 0; i < fw; i++) push(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    push(3'd0, 1, 0, 0, 1, 0, 0, 1, 0, 2'd0);
    push(3'd1, 0, 0, 0, 0, 0, 0, 1'($urandom), 0, 2'd0);
    push(3'd2, 0, 0, 0, 0, is_br, 0, 1'($urandom), 0, 2'd0);
    if (!is_br) begin
      if (is_ld || is_st) begin
        for (int i = 0; i < mw; i++) push(3'd3, 1, mrw, 1, 0, 0, 0, 0, 0, 2'd0);
        push(3'd3, 1, mrw, 1, 0, is_st, 0, 1, 0, 2'd0);
      end
      if (!is_st) push(3'd4, 0, 0, 0, 0, 1, rw, 1'($urandom), 0, 2'd0);
    end
  endtask

  // Applies the queued trace; abort_at >= 0 pulses rst in that cycle instead.
  task automatic run_trace(input int abort_at, output int dut_len);
    ent_t e;
    dut_len = 0;
    for (int i = 0; i < tr.size(); i++) begin
      e = tr[i];
      mem_ready = e.rdy;
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_mem_req", mem_req, 0); chk("abort_pc_we", pc_we, 0);
        chk("abort_rf_we", rf_we, 0);     chk("abort_mem_we", mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", state, 0); chk("abort_cycle_cnt", cycle_cnt, 0);
        chk("abort_instret", instret_cnt, 0);
        m_cyc = 32'd0; m_ret = 32'd0;
        break;
      end
      #1;
      chk("state", state, e.st);      chk("mem_req", mem_req, e.req);
      chk("mem_we", mem_we, e.we);    chk("mem_addr_sel", mem_addr_sel, e.asel);
      chk("ir_we", ir_we, e.irwe);    chk("pc_we", pc_we, e.pcwe);
      chk("rf_we", rf_we, e.rfwe);    chk("fault", fault, e.flt);
      chk("fault_code", fault_code, e.code);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instret_cnt", instret_cnt, m_ret);
      if (pc_we && dut_len == 0) dut_len = i + 1;
      @(posedge clk); #1;
      if (e.st != 3'd7) m_cyc = m_cyc + 32'd1;
      if (e.pcwe) m_ret = m_ret + 32'd1;
    end
    tr.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    chk("rst_mem_req", mem_req, 0); chk("rst_ir_we", ir_we, 0);
    chk("rst_pc_we", pc_we, 0);     chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state", state, 0);     chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0); chk("rst_instret", instret_cnt, 0);
    m_cyc = 32'd0; m_ret = 32'd0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic rw, mrw, input int fw, mw,
                           output int len);
    opcode = op; dec_RegWrite = rw; dec_MemRW = mrw;
    build_instr(op, rw, mrw, fw, mw);
    run_trace(-1, len);
  endtask

  vec_t        vecs[$];
  logic [6:0]  legal[7];
  int          len;

  initial begin
    legal = '{OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH, OP_JAL, OP_JALR};
    vecs.push_back('{OP_OP,     1'b1, 1'b0, 0, 0, 4});
    vecs.push_back('{OP_LOAD,   1'b1, 1'b0, 2, 1, 8});
    vecs.push_back('{OP_STORE,  1'b0, 1'b1, 0, 0, 4});
    vecs.push_back('{OP_BRANCH, 1'b0, 1'b0, 0, 0, 3});
    vecs.push_back('{OP_OPIMM,  1'b1, 1'b0, 1, 0, 5});
    vecs.push_back('{OP_JAL,    1'b1, 1'b0, 0, 0, 4});
    vecs.push_back('{OP_JALR,   1'b1, 1'b0, 0, 2, 4});
    vecs.push_back('{OP_STORE,  1'b0, 1'b1, 3, 3, 10});
    vecs.push_back('{OP_LOAD,   1'b0, 1'b0, 0, 0, 5});

    @(posedge clk); #1;
    do_reset();

    foreach (vecs[k]) begin
      run_instr(vecs[k].op, vecs[k].rw, vecs[k].mrw, vecs[k].fw, vecs[k].mw, len);
      chk($sformatf("latency_vec%0d", k), len, vecs[k].exp_len);
    end

    // Illegal LUI: FAULT two cycles after the fetch completes, then frozen.
    opcode = OP_LUI; dec_RegWrite = 1'b1; dec_MemRW = 1'b0;
    push(3'd0, 1, 0, 0, 1, 0, 0, 1, 0, 2'd0);
    push(3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    for (int i = 0; i < 20; i++) push(3'd7, 0, 0, 0, 0, 0, 0, 1'($urandom), 1, 2'd1);
    run_trace(-1, len);
    do_reset();

    // Fetch timeout: TMO+1 request cycles, then FAULT code 10.
    opcode = OP_OP; dec_RegWrite = 1'b1; dec_MemRW = 1'b0;
    for (int i = 0; i <= TMO; i++) push(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) push(3'd7, 0, 0, 0, 0, 0, 0, 1'($urandom), 1, 2'd2);
    run_trace(-1, len);
    do_reset();

    // Ready in the last allowed cycle wins over the timeout.
    run_instr(OP_OP, 1'b1, 1'b0, TMO, 0, len);
    chk("ready_at_timeout_len", len, TMO + 4);
    chk("ready_at_timeout_fault", fault, 0);

    // Data-phase timeout on a LOAD.
    opcode = OP_LOAD; dec_RegWrite = 1'b1; dec_MemRW = 1'b0;
    push(3'd0, 1, 0, 0, 1, 0, 0, 1, 0, 2'd0);
    push(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    push(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    for (int i = 0; i <= TMO; i++) push(3'd3, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 2; i++) push(3'd7, 0, 0, 0, 0, 0, 0, 1, 1, 2'd2);
    run_trace(-1, len);
    do_reset();

    // Reset pulsed during MEM of a LOAD after some retired work.
    run_instr(OP_OP, 1'b1, 1'b0, 0, 0, len);
    opcode = OP_LOAD; dec_RegWrite = 1'b1; dec_MemRW = 1'b0;
    build_instr(OP_LOAD, 1'b1, 1'b0, 0, 2);
    run_trace(4, len);

    // Random legal instructions against the trace model.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      op = legal[$urandom_range(0, 6)];
      run_instr(op, 1'($urandom), (op == OP_STORE) ? 1'b1 : 1'b0,
                int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)), len);
    end
    mem_ready = 1'b0;
    #1;
    chk("final_cycle_cnt", cycle_cnt, m_cyc);
    chk("final_instret", instret_cnt, m_ret);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
